// File: rtl/iluminacao_pkg.sv
// Shared types and default constants for the lighting chain (timer stage and lamp stage).
package iluminacao_pkg;

    typedef enum logic [1:0] {DESLIGADA, ACENDENDO, LIGADA, APAGANDO} lamp_state_t;

    localparam int DEBOUNCE_T_DEF  = 100;
    localparam int FADE_STEP_T_DEF = 50;
    localparam int PWM_BITS_DEF    = 4;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// Two-flop synchronizer and level debouncer for the raw wall push-button.
// A new level is accepted only after DEBOUNCE_T consecutive stable cycles.
module debounce_botao
    import iluminacao_pkg::*;
#(
    parameter int DEBOUNCE_T = DEBOUNCE_T_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic estavel,
    output logic pulso
);

    localparam int CW = cnt_width(DEBOUNCE_T);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_T - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_estavel;
    logic          r_pulso;
    logic [CW-1:0] r_db_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_estavel <= 1'b0;
            r_pulso   <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_pulso <= 1'b0;
            // Any return to the accepted level restarts the count.
            if (r_sync2 == r_estavel) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CNT_LAST) begin
                r_estavel <= r_sync2;
                r_db_cnt  <= '0;
                r_pulso   <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign estavel = r_estavel;
    assign pulso   = r_pulso;

endmodule

// File: rtl/controle_lampada.sv
// Lamp-drive stage: press toggles the lamp, C forces shutdown, brightness
// ramps softly between 0 and NIVEL_MAX and drives a free-running PWM.
module controle_lampada
    import iluminacao_pkg::*;
#(
    parameter int DEBOUNCE_T  = DEBOUNCE_T_DEF,
    parameter int FADE_STEP_T = FADE_STEP_T_DEF,
    parameter int PWM_BITS    = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_button,
    input  logic                C,
    output logic                led,
    output logic                saida,
    output logic [PWM_BITS-1:0] nivel
);

    localparam int SW = cnt_width(FADE_STEP_T);
    localparam logic [SW-1:0]       STEP_LAST = SW'(FADE_STEP_T - 1);
    localparam logic [PWM_BITS-1:0] NIVEL_MAX = '1;

    logic w_estavel;
    logic w_pulso;
    logic w_press;
    logic w_passo;
    logic [PWM_BITS-1:0] w_sobe;
    logic [PWM_BITS-1:0] w_desce;

    lamp_state_t         r_state;
    logic [SW-1:0]       r_step;
    logic [PWM_BITS-1:0] r_nivel;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_saida;
    logic                r_led;

    debounce_botao #(
        .DEBOUNCE_T (DEBOUNCE_T)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .raw     (push_button),
        .estavel (w_estavel),
        .pulso   (w_pulso)
    );

    assign w_press = w_pulso && w_estavel;
    assign w_passo = (r_step == STEP_LAST);
    assign w_sobe  = (r_nivel == NIVEL_MAX) ? NIVEL_MAX : r_nivel + 1'b1;
    assign w_desce = (r_nivel == '0) ? '0 : r_nivel - 1'b1;

    // state     | meaning
    // DESLIGADA | lamp off, nivel 0
    // ACENDENDO | on, ramping up one step every FADE_STEP_T cycles
    // LIGADA    | on, nivel held at NIVEL_MAX
    // APAGANDO  | off, ramping down towards 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DESLIGADA;
            r_step  <= '0;
            r_nivel <= '0;
            r_saida <= 1'b0;
        end else begin
            case (r_state)
                DESLIGADA: begin
                    r_step <= '0;
                    if (w_press && !C) begin
                        r_state <= ACENDENDO;
                        r_saida <= 1'b1;
                    end
                end
                ACENDENDO: begin
                    if (C || w_press) begin
                        r_state <= APAGANDO;
                        r_saida <= 1'b0;
                        r_step  <= '0;
                    end else if (w_passo) begin
                        r_step  <= '0;
                        r_nivel <= w_sobe;
                        if (w_sobe == NIVEL_MAX) r_state <= LIGADA;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                LIGADA: begin
                    r_step <= '0;
                    if (C || w_press) begin
                        r_state <= APAGANDO;
                        r_saida <= 1'b0;
                    end
                end
                APAGANDO: begin
                    if (w_press && !C) begin
                        r_state <= ACENDENDO;
                        r_saida <= 1'b1;
                        r_step  <= '0;
                    end else if (w_passo) begin
                        r_step  <= '0;
                        r_nivel <= w_desce;
                        if (w_desce == '0) r_state <= DESLIGADA;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                default: begin
                    r_state <= DESLIGADA;
                    r_step  <= '0;
                    r_saida <= 1'b0;
                end
            endcase
        end
    end

    // Full scale forces 100% duty; otherwise duty is nivel / 2**PWM_BITS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm_cnt <= '0;
            r_led     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_led     <= (r_nivel == NIVEL_MAX) || (r_pwm_cnt < r_nivel);
        end
    end

    assign led   = r_led;
    assign saida = r_saida;
    assign nivel = r_nivel;

endmodule
